// File: rtl/lcd_grid_fill.sv
// lcd_grid_fill: paints a GRID_ROWS x GRID_COLS grid of solid cells on an
// SPI-attached LCD controller. For each cell it sends a column window (0x2A),
// a row window (0x2B), and a memory write (0x2C) followed by the cell's pixels.
// Each byte is handed to an external SPI master with a one-cycle start pulse.
// The next byte is formed only after the master acknowledges with spi_ready.
module lcd_grid_fill #(
    parameter int unsigned GRID_ROWS = 10,
    parameter int unsigned GRID_COLS = 10,
    parameter int unsigned CELL_W    = 10,
    parameter int unsigned CELL_H    = 10,
    parameter logic [15:0] X0        = 16'd0,
    parameter logic [15:0] Y0        = 16'd0,
    parameter int unsigned PIX_BYTES = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        draw_en_i,
    input  logic        checker_i,
    input  logic [23:0] color_config_i,
    input  logic [23:0] color_alt_i,
    input  logic        abort_i,
    input  logic        spi_ready_i,
    output logic        spi_start_o,
    output logic [7:0]  spi_data_o,
    output logic        spi_dc_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [7:0]  cell_row_o,
    output logic [7:0]  cell_col_o
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_SEND = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_ADV  = 3'd4;

    // Byte slots within a cell: 0..10 are the window/command header,
    // SEG_PIXEL covers every pixel byte of the cell.
    localparam logic [3:0] SEG_CASET = 4'd0;
    localparam logic [3:0] SEG_RASET = 4'd5;
    localparam logic [3:0] SEG_RAMWR = 4'd10;
    localparam logic [3:0] SEG_PIXEL = 4'd11;

    localparam logic [15:0] PIX_LAST = 16'(CELL_W * CELL_H - 1);
    localparam logic [1:0]  SUB_LAST = 2'(PIX_BYTES - 1);
    localparam logic [7:0]  ROW_LAST = 8'(GRID_ROWS - 1);
    localparam logic [7:0]  COL_LAST = 8'(GRID_COLS - 1);

    logic [2:0]  state_q, state_d;
    logic [7:0]  row_q, row_d;
    logic [7:0]  col_q, col_d;
    logic [3:0]  seg_q, seg_d;
    logic [15:0] pix_q, pix_d;
    logic [1:0]  sub_q, sub_d;
    logic        checker_q, checker_d;
    logic [23:0] color_q, color_d;
    logic [23:0] alt_q, alt_d;
    logic        abort_q, abort_d;
    logic [7:0]  data_q, data_d;
    logic        dc_q, dc_d;

    logic [15:0] xs, xe, ys, ye;
    logic [23:0] pix_color;
    logic [7:0]  byte_val;
    logic        byte_dc;
    logic        pix_last;
    logic        grid_last;
    logic        adv_exit;

    // Window coordinates of the current cell, wrapping in 16 bits.
    always_comb begin
        xs = X0 + 16'(col_q) * 16'(CELL_W);
        xe = xs + 16'(CELL_W - 1);
        ys = Y0 + 16'(row_q) * 16'(CELL_H);
        ye = ys + 16'(CELL_H - 1);
    end

    // Form the byte for the current slot and whether it is command or data.
    always_comb begin
        pix_color = (checker_q && (row_q[0] ^ col_q[0])) ? alt_q : color_q;
        byte_val  = 8'h00;
        byte_dc   = 1'b1;
        case (seg_q)
            SEG_CASET: begin byte_val = 8'h2A; byte_dc = 1'b0; end
            4'd1:      byte_val = xs[15:8];
            4'd2:      byte_val = xs[7:0];
            4'd3:      byte_val = xe[15:8];
            4'd4:      byte_val = xe[7:0];
            SEG_RASET: begin byte_val = 8'h2B; byte_dc = 1'b0; end
            4'd6:      byte_val = ys[15:8];
            4'd7:      byte_val = ys[7:0];
            4'd8:      byte_val = ye[15:8];
            4'd9:      byte_val = ye[7:0];
            SEG_RAMWR: begin byte_val = 8'h2C; byte_dc = 1'b0; end
            default: begin
                if (PIX_BYTES == 2) begin
                    if (sub_q == 2'd0) begin
                        byte_val = {pix_color[23:19], pix_color[15:13]};
                    end else begin
                        byte_val = {pix_color[12:10], pix_color[7:3]};
                    end
                end else begin
                    case (sub_q)
                        2'd0:    byte_val = pix_color[23:16];
                        2'd1:    byte_val = pix_color[15:8];
                        default: byte_val = pix_color[7:0];
                    endcase
                end
            end
        endcase
    end

    // End-of-cell / end-of-grid detection for the byte just acknowledged.
    always_comb begin
        pix_last  = (seg_q == SEG_PIXEL) && (sub_q == SUB_LAST) && (pix_q == PIX_LAST);
        grid_last = (row_q == ROW_LAST) && (col_q == COL_LAST);
        adv_exit  = (state_q == S_ADV) && (abort_q || (pix_last && grid_last));
    end

    // Sequencer: start acceptance, byte hand-off, and cell/pixel stepping.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        seg_d     = seg_q;
        pix_d     = pix_q;
        sub_d     = sub_q;
        checker_d = checker_q;
        color_d   = color_q;
        alt_d     = alt_q;
        abort_d   = abort_q;
        data_d    = data_q;
        dc_d      = dc_q;
        case (state_q)
            S_IDLE: begin
                if (draw_en_i) begin
                    checker_d = checker_i;
                    color_d   = color_config_i;
                    alt_d     = color_alt_i;
                    abort_d   = 1'b0;
                    row_d     = 8'd0;
                    col_d     = 8'd0;
                    seg_d     = SEG_CASET;
                    pix_d     = 16'd0;
                    sub_d     = 2'd0;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                if (abort_i) begin
                    abort_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    data_d  = byte_val;
                    dc_d    = byte_dc;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (abort_i) begin
                    abort_d = 1'b1;
                end
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (abort_i) begin
                    abort_d = 1'b1;
                end
                if (spi_ready_i) begin
                    state_d = S_ADV;
                end
            end
            S_ADV: begin
                if (adv_exit) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_LOAD;
                    if (seg_q != SEG_PIXEL) begin
                        seg_d = seg_q + 4'd1;
                    end else if (sub_q != SUB_LAST) begin
                        sub_d = sub_q + 2'd1;
                    end else begin
                        sub_d = 2'd0;
                        if (pix_q != PIX_LAST) begin
                            pix_d = pix_q + 16'd1;
                        end else begin
                            pix_d = 16'd0;
                            seg_d = SEG_CASET;
                            if (col_q == COL_LAST) begin
                                col_d = 8'd0;
                                row_d = row_q + 8'd1;
                            end else begin
                                col_d = col_q + 8'd1;
                            end
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            row_q     <= 8'd0;
            col_q     <= 8'd0;
            seg_q     <= SEG_CASET;
            pix_q     <= 16'd0;
            sub_q     <= 2'd0;
            checker_q <= 1'b0;
            color_q   <= 24'd0;
            alt_q     <= 24'd0;
            abort_q   <= 1'b0;
            data_q    <= 8'd0;
            dc_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            seg_q     <= seg_d;
            pix_q     <= pix_d;
            sub_q     <= sub_d;
            checker_q <= checker_d;
            color_q   <= color_d;
            alt_q     <= alt_d;
            abort_q   <= abort_d;
            data_q    <= data_d;
            dc_q      <= dc_d;
        end
    end

    // Outputs derive only from registers; busy drops in the exiting ADV cycle.
    always_comb begin
        spi_start_o = (state_q == S_SEND);
        spi_data_o  = data_q;
        spi_dc_o    = dc_q;
        busy_o      = (state_q != S_IDLE) && !adv_exit;
        done_o      = (state_q == S_ADV) && !abort_q && pix_last && grid_last;
        cell_row_o  = row_q;
        cell_col_o  = col_q;
    end

endmodule

// File: doc/lcd_grid_fill.md
LCD_GRID_FILL -- requirements
Module: lcd_grid_fill

Interface
REQ-001 Parameter GRID_ROWS, default 10, number of cell rows (1..255).
REQ-002 Parameter GRID_COLS, default 10, number of cell columns (1..255).
REQ-003 Parameter CELL_W, default 10, cell width in pixels (1..255).
REQ-004 Parameter CELL_H, default 10, cell height in pixels (1..255).
REQ-005 Parameters X0 and Y0, default 0 each, 16-bit pixel origin of cell (0,0).
REQ-006 Parameter PIX_BYTES, default 2, pixel format: 2 = RGB565, 3 = RGB888.
REQ-007 clk  in  1  single clock; all logic on rising edge.
REQ-008 reset  in  1  asynchronous, active-low reset.
REQ-009 draw_en  in  1  start request, sampled in IDLE only.
REQ-010 checker  in  1  1 = alternate colours by cell parity; 0 = all cells color_config.
REQ-011 color_config  in  24  primary colour {R,G,B}, 8 bits each.
REQ-012 color_alt  in  24  secondary colour, used when checker=1 and (row+col) is odd.
REQ-013 abort  in  1  stop drawing after the in-flight byte completes.
REQ-014 spi_ready  in  1  one-cycle pulse from the SPI master: current byte transmitted.
REQ-015 spi_start  out  1  one-cycle pulse: spi_data/spi_dc are valid, transmit.
REQ-016 spi_data  out  8  byte to transmit.
REQ-017 spi_dc  out  1  0 = command byte, 1 = data byte.
REQ-018 busy  out  1  high from start acceptance until return to IDLE.
REQ-019 done  out  1  one-cycle pulse after the last byte of a complete grid.
REQ-020 cell_row, cell_col  out  8 each  indices of the cell being drawn.

Function
REQ-021 FSM states: IDLE, LOAD, SEND, WAIT, ADV.
- IDLE->LOAD on draw_en=1.
- LOAD->SEND after forming the byte.
- SEND->WAIT unconditionally.
- WAIT->ADV on spi_ready.
- ADV->LOAD if more bytes remain; otherwise ADV->IDLE.
REQ-022 On acceptance of draw_en, latch checker, color_config and color_alt; input changes during busy have no effect.
REQ-023 draw_en while busy=1 is ignored; no queuing.
REQ-024 spi_start is high for exactly the SEND cycle. spi_data/spi_dc are driven from LOAD and held stable until the next LOAD.
REQ-025 Per-cell byte order:
- 0x2A (cmd), then xs_hi, xs_lo, xe_hi, xe_lo (data);
- 0x2B (cmd), then ys_hi, ys_lo, ye_hi, ye_lo (data);
- 0x2C (cmd), then CELL_W*CELL_H pixels of PIX_BYTES data bytes each.
REQ-026 Coordinates:
- xs = X0 + col*CELL_W, xe = xs + CELL_W - 1;
- ys = Y0 + row*CELL_H, ye = ys + CELL_H - 1;
- all computed in 16 bits, wrapping modulo 2^16.
REQ-027 RGB565 pixel bytes: first byte {R[7:3],G[7:5]}, second byte {G[4:2],B[7:3]}. RGB888 pixel bytes: R, G, B in that order.
REQ-028 Cells are drawn row-major: col 0..GRID_COLS-1 within row 0..GRID_ROWS-1. cell_row/cell_col update in ADV after a cell's last pixel byte.
REQ-029 Pixel counter width is sufficient for CELL_W*CELL_H up to 65025 with no wrap.
REQ-030 done pulses in the ADV cycle that follows spi_ready of the final byte; busy falls in the same cycle.
REQ-031 spi_ready outside WAIT is ignored.
REQ-032 abort=1 in LOAD, SEND or WAIT sets a sticky abort flag. The flag is cleared on the next start acceptance.
REQ-033 With the abort flag set, the FSM completes the in-flight byte (SEND/WAIT), then goes to IDLE with no done pulse. An abort raised in LOAD suppresses that cycle's SEND.
REQ-034 abort in IDLE has no effect.

Reset
REQ-035 While reset=0:
- FSM is IDLE;
- spi_start, spi_data, spi_dc, busy, done, cell_row and cell_col are 0;
- latched colours and the abort flag are cleared.
REQ-036 Reset mid-transfer takes effect immediately (asynchronous). After reset releases, the block starts only on a new draw_en.

Verification
REQ-037 GRID 2x2, CELL 2x2, PIX_BYTES=2, color 0xFF0000, checker=0, draw_en pulse -> 76 spi_start pulses. Cell (0,0) sequence is 2A 00 00 00 01 2B 00 00 00 01 2C F8 00 F8 00 F8 00 F8 00, with spi_dc=0 exactly on 2A/2B/2C. One done pulse follows.
REQ-038 Same setup, cell (1,1) -> x window bytes 00 02 00 03, y window bytes 00 02 00 03.
REQ-039 checker=1, color_config 0x0000FF, color_alt 0x00FF00 -> cells (0,1) and (1,0) send pixel bytes 07 E0; cells (0,0) and (1,1) send 00 1F.
REQ-040 PIX_BYTES=3, color 0x123456, 1x1 grid, 1x1 cell -> 14 bytes, ending 12 34 56.
REQ-041 Hold spi_ready low for 20 cycles after a spi_start -> no further spi_start, spi_data stable. A spurious spi_ready in IDLE -> no output change.
REQ-042 reset=0 after the 5th byte -> all outputs 0 immediately. abort after the 5th byte -> exactly one more spi_ready is awaited, then busy=0 and no done.
